// File: rtl/adda_capture_ctrl_pkg.sv
// Shared state encoding and counter widths for the addr/data capture sequencer.
package adda_capture_ctrl_pkg;

    localparam int DROP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/adda_edge_det.sv
// One-flop rising-edge detector on a level that is synchronous to clk.
// Pulse is combinational in the cycle the level first reads high; no backpressure.
module adda_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_lvl,
    output logic o_pulse
);

    logic r_lvl_d1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl_d1 <= 1'b0;
        end else begin
            r_lvl_d1 <= i_lvl;
        end
    end

    assign o_pulse = i_lvl & ~r_lvl_d1;

endmodule

// File: rtl/adda_capture_ctrl.sv
// Trigger/window capture sequencer feeding the JTAG capture FIFO; one-cycle hit-to-write latency.
// Almost-full on the FIFO drops hits (counted in drop_cnt) instead of stalling the bus.
module adda_capture_ctrl
    import adda_capture_ctrl_pkg::*;
#(
    parameter int addr_width  = 32,
    parameter int data_width  = 82,
    parameter int cnt_width   = 10,
    parameter int al_full_val = 511
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cap_valid,
    input  logic [addr_width-1:0] cap_addr,
    input  logic [data_width-1:0] cap_data,
    input  logic                  cfg_arm,
    input  logic                  cfg_abort,
    input  logic [addr_width-1:0] cfg_trig_addr,
    input  logic [addr_width-1:0] cfg_lo_addr,
    input  logic [addr_width-1:0] cfg_hi_addr,
    input  logic [cnt_width-1:0]  cfg_post_cnt,
    input  logic [cnt_width-1:0]  fifo_usedw,
    output logic                  fifo_wr,
    output logic [data_width-1:0] fifo_din,
    output logic [1:0]            state,
    output logic [DROP_W-1:0]     drop_cnt
);

    state_t                r_state;
    logic                  r_fifo_wr;
    logic [data_width-1:0] r_fifo_din;
    logic [cnt_width-1:0]  r_post_left;
    logic [DROP_W-1:0]     r_drop_cnt;

    state_t                w_state_nxt;
    logic                  w_wr;
    logic [cnt_width-1:0]  w_post_nxt;
    logic                  w_drop_clr;
    logic                  w_drop_inc;
    logic                  w_arm_pulse;
    logic                  w_abort_pulse;
    logic                  w_trig_hit;
    logic                  w_win_hit;
    logic                  w_al_full;

    adda_edge_det u_arm_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_lvl   (cfg_arm),
        .o_pulse (w_arm_pulse)
    );

    adda_edge_det u_abort_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_lvl   (cfg_abort),
        .o_pulse (w_abort_pulse)
    );

    assign w_trig_hit = cap_valid && (cap_addr == cfg_trig_addr);
    // An inverted window (lo > hi) never matches, so CAPTURE only leaves via abort.
    assign w_win_hit  = cap_valid && (cap_addr >= cfg_lo_addr) && (cap_addr <= cfg_hi_addr);
    assign w_al_full  = fifo_usedw >= cnt_width'(al_full_val);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_post_nxt  = r_post_left;
        w_drop_clr  = 1'b0;
        w_drop_inc  = 1'b0;
        if (w_abort_pulse) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_drop_clr = 1'b1;
                    w_post_nxt = '0;
                    if (w_arm_pulse) w_state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_trig_hit) begin
                        if (w_al_full) begin
                            w_drop_inc = 1'b1;
                        end else begin
                            w_wr        = 1'b1;
                            w_post_nxt  = cfg_post_cnt;
                            w_state_nxt = (cfg_post_cnt == '0) ? ST_DONE : ST_CAPTURE;
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (w_win_hit) begin
                        if (w_al_full) begin
                            w_drop_inc = 1'b1;
                        end else begin
                            w_wr       = 1'b1;
                            w_post_nxt = r_post_left - cnt_width'(1);
                            if (r_post_left == cnt_width'(1)) w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (w_arm_pulse) begin
                        w_state_nxt = ST_ARMED;
                        w_drop_clr  = 1'b1;
                        w_post_nxt  = '0;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_wr   <= 1'b0;
            r_fifo_din  <= '0;
            r_post_left <= '0;
            r_drop_cnt  <= '0;
        end else begin
            r_fifo_wr   <= w_wr;
            r_post_left <= w_post_nxt;
            if (w_wr) r_fifo_din <= cap_data;
            if (w_drop_clr) begin
                r_drop_cnt <= '0;
            end else if (w_drop_inc && (r_drop_cnt != {DROP_W{1'b1}})) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

    assign fifo_wr  = r_fifo_wr;
    assign fifo_din = r_fifo_din;
    assign state    = r_state;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_adda_capture_ctrl.sv
// Directed table-driven bench for adda_capture_ctrl plus hand sequences for reset and empty window.
module tb_adda_capture_ctrl;

    localparam int AW = 32;
    localparam int DW = 82;
    localparam int CW = 10;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ARM  = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cap_valid;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_data;
    logic          cfg_arm;
    logic          cfg_abort;
    logic [AW-1:0] cfg_trig_addr;
    logic [AW-1:0] cfg_lo_addr;
    logic [AW-1:0] cfg_hi_addr;
    logic [CW-1:0] cfg_post_cnt;
    logic [CW-1:0] fifo_usedw;
    logic          fifo_wr;
    logic [DW-1:0] fifo_din;
    logic [1:0]    state;
    logic [15:0]   drop_cnt;

    int n_checks = 0;
    int n_err    = 0;

    adda_capture_ctrl #(
        .addr_width  (AW),
        .data_width  (DW),
        .cnt_width   (CW),
        .al_full_val (511)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cap_valid     (cap_valid),
        .cap_addr      (cap_addr),
        .cap_data      (cap_data),
        .cfg_arm       (cfg_arm),
        .cfg_abort     (cfg_abort),
        .cfg_trig_addr (cfg_trig_addr),
        .cfg_lo_addr   (cfg_lo_addr),
        .cfg_hi_addr   (cfg_hi_addr),
        .cfg_post_cnt  (cfg_post_cnt),
        .fifo_usedw    (fifo_usedw),
        .fifo_wr       (fifo_wr),
        .fifo_din      (fifo_din),
        .state         (state),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          vld;
        logic [AW-1:0] addr;
        logic          arm;
        logic          abort;
        logic [CW-1:0] usedw;
        logic [CW-1:0] post;
        logic          exp_wr;
        logic [1:0]    exp_st;
        logic [15:0]   exp_drop;
    } vec_t;

    vec_t vt[26];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mk_data(input int tag, input logic [AW-1:0] addr);
        return {50'(tag), addr};
    endfunction

    // Drive on the falling edge, one rising edge, then sample 1 ns later.
    task automatic step(input logic vld, input logic [AW-1:0] addr, input int tag);
        @(negedge clk);
        cap_valid = vld;
        cap_addr  = addr;
        cap_data  = mk_data(tag, addr);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vt[0]  = '{0, 32'h0000, 0, 0, 0,   3, 0, S_IDLE, 0};
        vt[1]  = '{0, 32'h0000, 1, 0, 0,   3, 0, S_ARM,  0};
        vt[2]  = '{1, 32'h2000, 1, 0, 0,   3, 0, S_ARM,  0};
        vt[3]  = '{1, 32'h1000, 1, 0, 0,   3, 1, S_CAP,  0};
        vt[4]  = '{1, 32'h0FFF, 1, 0, 0,   3, 0, S_CAP,  0};
        vt[5]  = '{1, 32'h1100, 1, 0, 0,   3, 0, S_CAP,  0};
        vt[6]  = '{1, 32'h10FF, 1, 0, 0,   3, 1, S_CAP,  0};
        vt[7]  = '{1, 32'h1010, 1, 0, 511, 3, 0, S_CAP,  1};
        vt[8]  = '{1, 32'h1010, 1, 0, 511, 3, 0, S_CAP,  2};
        vt[9]  = '{1, 32'h1020, 1, 0, 511, 3, 0, S_CAP,  3};
        vt[10] = '{1, 32'h1030, 1, 0, 500, 3, 1, S_CAP,  3};
        vt[11] = '{1, 32'h1040, 1, 0, 0,   3, 1, S_DONE, 3};
        vt[12] = '{1, 32'h1050, 1, 0, 0,   3, 0, S_DONE, 3};
        vt[13] = '{1, 32'h1060, 1, 0, 0,   3, 0, S_DONE, 3};
        vt[14] = '{0, 32'h0000, 0, 0, 0,   3, 0, S_DONE, 3};
        vt[15] = '{0, 32'h0000, 1, 0, 0,   0, 0, S_ARM,  0};
        vt[16] = '{1, 32'h1000, 1, 0, 0,   0, 1, S_DONE, 0};
        vt[17] = '{0, 32'h0000, 1, 1, 0,   0, 0, S_IDLE, 0};
        vt[18] = '{0, 32'h0000, 0, 1, 0,   0, 0, S_IDLE, 0};
        vt[19] = '{0, 32'h0000, 1, 0, 0,   0, 0, S_ARM,  0};
        vt[20] = '{1, 32'h1000, 1, 1, 0,   0, 0, S_IDLE, 0};
        vt[21] = '{1, 32'h1000, 1, 0, 0,   0, 0, S_IDLE, 0};
        vt[22] = '{0, 32'h0000, 0, 0, 0,   2, 0, S_IDLE, 0};
        vt[23] = '{0, 32'h0000, 1, 0, 0,   2, 0, S_ARM,  0};
        vt[24] = '{1, 32'h1000, 1, 0, 511, 2, 0, S_ARM,  1};
        vt[25] = '{1, 32'h1000, 1, 0, 0,   2, 1, S_CAP,  1};

        rst_n         = 1'b0;
        cap_valid     = 1'b0;
        cap_addr      = '0;
        cap_data      = '0;
        cfg_arm       = 1'b0;
        cfg_abort     = 1'b0;
        cfg_trig_addr = 32'h1000;
        cfg_lo_addr   = 32'h1000;
        cfg_hi_addr   = 32'h10FF;
        cfg_post_cnt  = 10'd3;
        fifo_usedw    = '0;

        #12;
        chk("reset wr",    DW'(fifo_wr),  DW'(0));
        chk("reset din",   fifo_din,      DW'(0));
        chk("reset state", DW'(state),    DW'(S_IDLE));
        chk("reset drop",  DW'(drop_cnt), DW'(0));
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            cap_valid    = vt[i].vld;
            cap_addr     = vt[i].addr;
            cap_data     = mk_data(i + 1, vt[i].addr);
            cfg_arm      = vt[i].arm;
            cfg_abort    = vt[i].abort;
            fifo_usedw   = vt[i].usedw;
            cfg_post_cnt = vt[i].post;
            @(posedge clk);
            #1;
            chk($sformatf("row%0d wr", i),    DW'(fifo_wr),  DW'(vt[i].exp_wr));
            chk($sformatf("row%0d state", i), DW'(state),    DW'(vt[i].exp_st));
            chk($sformatf("row%0d drop", i),  DW'(drop_cnt), DW'(vt[i].exp_drop));
            if (vt[i].exp_wr)
                chk($sformatf("row%0d din", i), fifo_din, mk_data(i + 1, vt[i].addr));
        end

        // Asynchronous reset mid-CAPTURE with a window hit pending.
        @(negedge clk);
        cap_valid = 1'b1;
        cap_addr  = 32'h1010;
        cap_data  = mk_data(200, 32'h1010);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst wr",    DW'(fifo_wr),  DW'(0));
        chk("midrst din",   fifo_din,      DW'(0));
        chk("midrst state", DW'(state),    DW'(S_IDLE));
        chk("midrst drop",  DW'(drop_cnt), DW'(0));
        @(negedge clk);
        cap_valid = 1'b0;
        rst_n     = 1'b1;
        #1;
        chk("release state", DW'(state), DW'(S_IDLE));
        @(posedge clk);
        #1;
        chk("arm-held state", DW'(state), DW'(S_ARM));
        chk("arm-held wr",    DW'(fifo_wr), DW'(0));

        // Inverted window: trigger captures, nothing else ever qualifies.
        cfg_lo_addr  = 32'h2000;
        cfg_hi_addr  = 32'h1000;
        cfg_post_cnt = 10'd2;
        step(1'b1, 32'h1000, 300);
        chk("empty trig wr",    DW'(fifo_wr), DW'(1));
        chk("empty trig din",   fifo_din,     mk_data(300, 32'h1000));
        chk("empty trig state", DW'(state),   DW'(S_CAP));
        step(1'b1, 32'h1000, 301);
        chk("empty hit0 wr", DW'(fifo_wr), DW'(0));
        step(1'b1, 32'h1800, 302);
        chk("empty hit1 wr", DW'(fifo_wr), DW'(0));
        step(1'b1, 32'h2000, 303);
        chk("empty hit2 wr",    DW'(fifo_wr), DW'(0));
        chk("empty hit2 state", DW'(state),   DW'(S_CAP));
        @(negedge clk);
        cfg_abort = 1'b1;
        step(1'b1, 32'h1000, 304);
        chk("empty abort state", DW'(state),   DW'(S_IDLE));
        chk("empty abort wr",    DW'(fifo_wr), DW'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/adda_capture_ctrl.md
# adda_capture_ctrl

Capture sequencer in front of the addr/data JTAG capture FIFO. Qualifies bus transactions against a trigger address and an address window, counts post-trigger captures, and issues registered write strobes into the FIFO. The FIFO is drained by the host over JTAG. Arm and abort are level controls driven from the host VIO, synchronous to `clk`.

## Interface
Parameters:
- `addr_width` (32): width of the observed bus address.
- `data_width` (82): width of the capture word written to the FIFO.
- `cnt_width` (10): width of the FIFO fill level and post-trigger counter.
- `al_full_val` (511): fill level at which writes are suppressed.

Ports:
- `clk` in 1: sole clock.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `cap_valid` in 1: one-cycle strobe marking a bus transaction.
- `cap_addr` in `addr_width`: transaction address.
- `cap_data` in `data_width`: capture word (addr/data/attributes, pre-packed).
- `cfg_arm` in 1: host arm level; the rising edge arms.
- `cfg_abort` in 1: host abort level; the rising edge aborts.
- `cfg_trig_addr` in `addr_width`: trigger address.
- `cfg_lo_addr`, `cfg_hi_addr` in `addr_width`: inclusive capture window.
- `cfg_post_cnt` in `cnt_width`: number of window hits captured after the trigger.
- `fifo_usedw` in `cnt_width`: FIFO fill level.
- `fifo_wr` out 1: FIFO write strobe.
- `fifo_din` out `data_width`: FIFO write data.
- `state` out 2: 0=IDLE, 1=ARMED, 2=CAPTURE, 3=DONE.
- `drop_cnt` out 16: saturating count of window hits lost to almost-full.

## Operation
- Edge detect: one register per level input; `arm_pulse = cfg_arm & ~arm_d1`, `abort_pulse` likewise.
- States and transitions:
  - IDLE: `arm_pulse` -> ARMED. Clears `post_left` and `drop_cnt`.
  - ARMED: `cap_valid & cap_addr==cfg_trig_addr` -> writes the trigger word. Then `post_left <= cfg_post_cnt` and -> CAPTURE, or -> DONE if `cfg_post_cnt==0`.
  - CAPTURE: a window hit (`cap_valid & lo<=addr<=hi`, unsigned) writes the word and decrements `post_left`. At `post_left==1` on a write -> DONE.
  - DONE: holds. `arm_pulse` -> ARMED, clearing the counters.
- `abort_pulse` in any state -> IDLE. Abort has priority over every other event in the same cycle; no write is issued in that cycle.
- Almost full (`fifo_usedw >= al_full_val`): a hit is not written and does not decrement `post_left`. `drop_cnt` increments and saturates at 0xFFFF.
  - A trigger seen while almost full is dropped. The block stays ARMED and counts the drop.
- `lo > hi`: empty window. CAPTURE then never completes until abort.
- `cfg_*` values are sampled live; the host must hold them stable while ARMED or in CAPTURE.

## Timing
- Reset values: `fifo_wr=0`, `fifo_din=0`, `state=IDLE`, `drop_cnt=0`, edge registers=0.
  - A level already high at reset release is treated as an edge on the first clock.
- Latency: `cap_valid` in cycle N -> `fifo_wr`/`fifo_din` in cycle N+1, single-cycle strobe. Back-to-back hits produce back-to-back writes.
- `state` is registered and updates in cycle N+1 alongside the write.
- Arm: `cfg_arm` rises in cycle N -> `state==ARMED` in cycle N+1. A trigger in that N+1 cycle is accepted.
- Almost-full is evaluated combinationally on `fifo_usedw` in cycle N.
  - Writes in flight are not counted, so `al_full_val` is at least 1 below FIFO depth.
- Reset mid-capture returns to IDLE immediately. A pending write is lost.

## Structure
- Shared package: state encoding constants (`ST_IDLE`..`ST_DONE`) and the `drop_cnt` width (16).
- One natural sub-module: `adda_edge_det`, a one-flop rising-edge detector instantiated for `cfg_arm` and `cfg_abort`.
- FSM, window compare, `post_left` counter and output register stay in the top.

## Test plan
- Basic capture: arm; trigger 0x1000 hit; window 0x1000–0x10FF with `post_cnt=3`; five window hits.
  - -> 4 writes (trigger + 3), then DONE. Hits 4–5 are not written.
- Out-of-window: in CAPTURE, addresses 0x0FFF and 0x1100 -> no write. 0x10FF -> write (inclusive bound).
- `post_cnt=0`: trigger -> single write, `state` ARMED -> DONE in the same cycle as `fifo_wr`.
- Almost full: `fifo_usedw=511` during 3 hits -> no writes, `drop_cnt=3`, `post_left` unchanged.
  - Lower `usedw` to 500 -> capture resumes.
- Abort priority: `abort_pulse` in the same cycle as the trigger -> no write, `state=IDLE`.
- Reset: assert `rst_n` low mid-CAPTURE -> all outputs at reset values asynchronously.
  - `cfg_arm` held high through release -> ARMED after the first clock.
